// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: data width, FIFO sizing and
// idle-timeout defaults, plus a counter-width helper.
package uart_pkg;

    localparam int BYTE_W     = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;
    localparam int RX_TIMEOUT = 4096;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through byte FIFO with extended pointers; accepts a push
// while full when a pop happens on the same edge.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW,
    parameter int DW    = BYTE_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   level_o,
    output logic          pop_ok_o,
    output logic          drop_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          push_ok;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o  = wr_ptr_q - rd_ptr_q;

    // A pop on the same edge frees the slot a full FIFO needs for the push.
    assign pop_ok_o = pop_i & ~empty_o;
    assign push_ok  = push_i & (~full_o | pop_ok_o);
    assign drop_o   = push_i & ~push_ok;

    // Head is forced to zero while empty so the output is defined after reset.
    assign rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok_o) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: synchronises the Receiver's data_ready, pushes one
// byte per rising edge into the FIFO, and raises overrun/timeout/threshold irq.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH   = FIFO_DEPTH,
    parameter int AW      = FIFO_AW,
    parameter int TIMEOUT = RX_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [BYTE_W-1:0] rx_byte_i,
    input  logic              rx_ready_i,
    input  logic              rd_en_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AW:0]       level_o,
    input  logic [AW:0]       rx_thresh_i,
    input  logic              clr_overrun_i,
    output logic              overrun_o,
    output logic              timeout_o,
    output logic              irq_o
);

    localparam int          TW     = cnt_width(TIMEOUT);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    // [0],[1] form the synchroniser, [2] remembers the previous synced level.
    logic [2:0]    sync_q, sync_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          overrun_q, overrun_d;
    logic          irq_q, irq_d;
    logic          push;
    logic          pop_ok;
    logic          drop;
    logic          thresh_hit;

    assign sync_d = {sync_q[1:0], rx_ready_i};
    assign push   = sync_q[1] & ~sync_q[2];

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (BYTE_W)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_i   (push),
        .pop_i    (rd_en_i),
        .wdata_i  (rx_byte_i),
        .rdata_o  (rd_data_o),
        .empty_o  (empty_o),
        .full_o   (full_o),
        .level_o  (level_o),
        .pop_ok_o (pop_ok),
        .drop_o   (drop)
    );

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (push || pop_ok || empty_o) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    assign timeout_o = (to_cnt_q == TO_MAX) && !empty_o;

    // A drop on the same edge as a clear keeps the flag set.
    always_comb begin
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    // Thresholds above DEPTH can never be met by the level, so they never fire.
    assign thresh_hit = (rx_thresh_i != '0) && (level_o >= rx_thresh_i);
    assign irq_d      = thresh_hit | timeout_o | overrun_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            to_cnt_q  <= '0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            to_cnt_q  <= to_cnt_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    assign overrun_o = overrun_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a randomized
// run against a queue-based reference model of the receive controller.
module tb_uart_rx_ctrl;

    localparam int D   = 8;
    localparam int AWL = 3;
    localparam int T   = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     rx_byte = 8'h00;
    logic           rx_ready = 1'b0;
    logic           rd_en = 1'b0;
    logic           clr_ovr = 1'b0;
    logic [AWL:0]   thresh = '0;
    logic [7:0]     rd_data;
    logic           empty, full, overrun, timeout, irq;
    logic [AWL:0]   level;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q_m[$];
    bit         hist[$];
    bit         m_ovr, m_irq;
    int         m_idle;
    logic [7:0] e_rd;
    bit         e_empty, e_full, e_to;
    int         e_level;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(D), .AW(AWL), .TIMEOUT(T)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_byte_i     (rx_byte),
        .rx_ready_i    (rx_ready),
        .rd_en_i       (rd_en),
        .rd_data_o     (rd_data),
        .empty_o       (empty),
        .full_o        (full),
        .level_o       (level),
        .rx_thresh_i   (thresh),
        .clr_overrun_i (clr_ovr),
        .overrun_o     (overrun),
        .timeout_o     (timeout),
        .irq_o         (irq)
    );

    task automatic refresh_exp();
        e_level = q_m.size();
        e_empty = (e_level == 0);
        e_full  = (e_level == D);
        e_rd    = e_empty ? 8'h00 : q_m[0];
        e_to    = (m_idle == T - 1) && !e_empty;
    endtask

    task automatic model_clear();
        q_m.delete();
        hist.delete();
        repeat (3) hist.push_back(1'b0);
        m_ovr  = 0;
        m_irq  = 0;
        m_idle = 0;
        refresh_exp();
    endtask

    // Advance one clock: update the model from the inputs in force before the
    // edge, then sample the DUT 1 time unit after the edge.
    task automatic cycle();
        int sz, idle_n;
        bit push, pop, ovr_set, irq_n;
        if (!rst_n) begin
            model_clear();
        end else begin
            sz    = q_m.size();
            // a rising rx_ready seen two edges ago commits on this edge
            push  = hist[hist.size() - 2] && !hist[hist.size() - 3];
            pop   = rd_en && (sz > 0);
            irq_n = ((thresh != 0) && (sz >= int'(thresh))) ||
                    ((m_idle == T - 1) && (sz > 0)) || m_ovr;
            if (push || pop || sz == 0) idle_n = 0;
            else idle_n = (m_idle < T - 1) ? m_idle + 1 : T - 1;
            ovr_set = 0;
            if (pop) void'(q_m.pop_front());
            if (push) begin
                if (sz < D || pop) q_m.push_back(rx_byte);
                else ovr_set = 1;
            end
            if (ovr_set) m_ovr = 1;
            else if (clr_ovr) m_ovr = 0;
            m_irq  = irq_n;
            m_idle = idle_n;
            hist.push_back(rx_ready);
            if (hist.size() > 6) void'(hist.pop_front());
        end
        @(posedge clk);
        #1;
        refresh_exp();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_ready = 1'b1;
        cycle();
        cycle();
        rx_ready = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic drain();
        rx_ready = 1'b0;
        cycle();
        cycle();
        cycle();
        for (int i = 0; i < 3 * D && q_m.size() > 0; i++) begin
            rd_en = 1'b1;
            cycle();
        end
        rd_en = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
        rst_n = 1'b1;
        cycle();
        $display("test_reset done");
    endtask

    task automatic test_reset_mid_push();
        rx_byte  = 8'h77;
        rx_ready = 1'b1;
        cycle();
        rst_n = 1'b0;
        model_clear();
        rx_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        repeat (4) cycle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got=%b exp=1", empty); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL midrst_level got=%0d exp=0", level); end
        rx_byte  = 8'h3C;
        rx_ready = 1'b1;
        repeat (3) cycle();
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL midrst_relevel got=%0d exp=1", level); end
        checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL midrst_data got=%h exp=3c", rd_data); end
        drain();
        $display("test_reset_mid_push done");
    endtask

    task automatic test_single_byte();
        rx_byte  = 8'hA5;
        rx_ready = 1'b1;
        cycle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_e1 got=%b exp=1", empty); end
        cycle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_e2 got=%b exp=1", empty); end
        cycle();
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_e3 got=%b exp=0", empty); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", rd_data); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
        for (int i = 0; i < 50; i++) begin
            cycle();
            checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_hold cyc=%0d got=%0d exp=1", i, level); end
        end
        rx_ready = 1'b0;
        cycle();
        cycle();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL single_pop_level got=%0d exp=0", level); end
        $display("test_single_byte done");
    endtask

    task automatic test_fill_overrun();
        for (int b = 1; b <= 9; b++) send_byte(8'(b));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL fill_level got=%0d exp=8", level); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL fill_overrun got=%b exp=1", overrun); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fill_irq got=%b exp=1", irq); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL fill_read idx=%0d got=%h exp=%h", i, rd_data, 8'(i)); end
            rd_en = 1'b1;
            cycle();
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained got=%b exp=1", empty); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL fill_sticky got=%b exp=1", overrun); end
        clr_ovr = 1'b1;
        cycle();
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fill_clr got=%b exp=0", overrun); end
        $display("test_fill_overrun done");
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_seq[8];
        for (int b = 0; b < 8; b++) send_byte(8'h11 + 8'(b));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ppf_full got=%b exp=1", full); end
        rx_byte  = 8'h55;
        rx_ready = 1'b1;
        cycle();
        cycle();
        rd_en = 1'b1;
        cycle();
        rd_en    = 1'b0;
        rx_ready = 1'b0;
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ppf_level got=%0d exp=8", level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ppf_overrun got=%b exp=0", overrun); end
        for (int i = 0; i < 7; i++) exp_seq[i] = 8'h12 + 8'(i);
        exp_seq[7] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rd_data !== exp_seq[i]) begin errors++; $display("FAIL ppf_read idx=%0d got=%h exp=%h", i, rd_data, exp_seq[i]); end
            rd_en = 1'b1;
            cycle();
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ppf_drained got=%b exp=1", empty); end
        $display("test_push_pop_full done");
    endtask

    task automatic test_threshold();
        thresh = 4'd3;
        send_byte(8'hB0);
        send_byte(8'hB1);
        checks++; if (level !== 4'd2) begin errors++; $display("FAIL thr_level2 got=%0d exp=2", level); end
        cycle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_irq_lvl2 got=%b exp=0", irq); end
        rx_byte  = 8'hB2;
        rx_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        rx_ready = 1'b0;
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL thr_level3 got=%0d exp=3", level); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_irq_same_edge got=%b exp=0", irq); end
        cycle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL thr_irq_next got=%b exp=1", irq); end
        thresh = 4'd0;
        for (int b = 0; b < 5; b++) send_byte(8'hC0 + 8'(b));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL thr0_full got=%b exp=1", full); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr0_irq got=%b exp=0", irq); end
        drain();
        $display("test_threshold done");
    endtask

    task automatic test_timeout();
        thresh   = 4'd0;
        rx_byte  = 8'hC3;
        rx_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        rx_ready = 1'b0;
        for (int j = 1; j < T - 1; j++) begin
            cycle();
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early idle=%0d got=%b exp=0", j, timeout); end
        end
        cycle();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_fire got=%b exp=1", timeout); end
        cycle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL to_irq got=%b exp=1", irq); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_hold got=%b exp=1", timeout); end
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pop_clear got=%b exp=0", timeout); end
        cycle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL to_irq_clear got=%b exp=0", irq); end
        for (int j = 0; j < 40; j++) begin
            cycle();
            checks++; if (timeout !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL to_empty cyc=%0d got=%b%b exp=00", j, timeout, irq); end
        end
        $display("test_timeout done");
    endtask

    task automatic test_random();
        int rd_pct;
        for (int i = 0; i < 2000; i++) begin
            rd_pct = ((i / 250) % 3 == 0) ? 5 : (((i / 250) % 3 == 1) ? 35 : 0);
            if (!rx_ready) begin
                if ($urandom_range(0, 99) < 40) begin
                    rx_byte  = 8'($urandom);
                    rx_ready = 1'b1;
                end
            end else if ($urandom_range(0, 99) < 50) begin
                rx_ready = 1'b0;
            end
            if ((i / 250) % 3 == 2 && (i % 250) > 100) rx_ready = 1'b0;
            rd_en   = ($urandom_range(0, 99) < rd_pct);
            clr_ovr = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 3) thresh = 4'($urandom_range(0, 15));
            cycle();
            checks++; if (empty !== e_empty) begin errors++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", i, empty, e_empty); end
            checks++; if (full !== e_full) begin errors++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", i, full, e_full); end
            checks++; if (level !== 4'(e_level)) begin errors++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level, e_level); end
            checks++; if (rd_data !== e_rd) begin errors++; $display("FAIL rnd_rd_data cyc=%0d got=%h exp=%h", i, rd_data, e_rd); end
            checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun cyc=%0d got=%b exp=%b", i, overrun, m_ovr); end
            checks++; if (timeout !== e_to) begin errors++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", i, timeout, e_to); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", i, irq, m_irq); end
        end
        rd_en   = 1'b0;
        clr_ovr = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        model_clear();
        test_reset();
        test_reset_mid_push();
        test_single_byte();
        test_fill_overrun();
        test_push_pop_full();
        test_threshold();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller between the UART Receiver (rhr_data/data_ready) and the host bus. Detects each new received byte and buffers it in a small first-word-fall-through FIFO. Flags overrun and raises an interrupt on a programmable fill threshold or on a character-idle timeout. Lives in the RX top level alongside the baud generator and Receiver; all logic is on the system clock.

Parameters:
DEPTH, 8, FIFO entries (power of 2, minimum 2)
AW, 3, log2(DEPTH)
TIMEOUT, 4096, idle clk cycles with a non-empty FIFO before the timeout interrupt

Ports:
clk  in  1  system clock, all flops rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
rx_byte  in  8  Receiver holding register; stable while rx_ready is high
rx_ready  in  1  Receiver data_ready level; treated as asynchronous to clk
rd_en  in  1  host pop request
rd_data  out  8  FIFO head; valid when empty=0
empty  out  1  FIFO empty
full  out  1  FIFO full
level  out  AW+1  entries held, 0..DEPTH
rx_thresh  in  AW+1  interrupt threshold; 0 disables the threshold source
clr_overrun  in  1  clears the sticky overrun flag
overrun  out  1  sticky: a byte was dropped
timeout  out  1  idle-timeout flag
irq  out  1  registered interrupt

Behaviour:
- Reset values: empty=1, full=0, level=0, overrun=0, timeout=0, irq=0, rd_data=0. Pointers, sync flops and timeout counter all clear. Reset acts immediately and aborts any pending push; the FIFO contents are discarded.
- rx_ready passes through a 2-flop synchroniser (s1, s2), then an edge register s3. push = s2 & ~s3 (one-cycle pulse per rising edge).
- Latency: rx_ready high sampled at edge k -> push is true during cycle k+1..k+2 -> the write commits at edge k+2. At that point rx_byte is sampled, then empty=0 and level increments.
- The level of rx_ready is ignored; only one push per rising edge. A held-high rx_ready never re-pushes.
- Pop: rd_en=1 with empty=0 advances the read pointer at the clock edge. rd_data is combinational from the head (FWFT). rd_en while empty is ignored with no state change.
- Push while not full: write at wr_ptr, wr_ptr+1 mod DEPTH.
- Push and pop in the same cycle:
  - Both are performed; level is unchanged.
  - This also applies when full: pop frees a slot and the push is accepted, with no overrun.
  - When empty, the push proceeds and the pop is ignored.
- Push while full without pop: the byte is dropped and overrun is set at that edge.
- overrun is sticky until clr_overrun=1. A set and clear in the same cycle: set wins.
- Pointers are AW+1 bits. full = (MSBs differ and low bits equal). empty = (pointers equal). level = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Timeout counter:
  - Clears on push, on pop, or while empty.
  - Otherwise increments, saturating at TIMEOUT-1.
  - timeout=1 while the counter equals TIMEOUT-1 and empty=0.
  - The count (TIMEOUT-1) is reached on the edge ending TIMEOUT-1 idle cycles; timeout falls on the next push, pop, or when the FIFO empties.
- irq (registered, one cycle after its cause) = ((rx_thresh!=0) & (level >= rx_thresh)) | timeout | overrun.
- rx_thresh > DEPTH means the threshold source never fires; no clamping is applied.

Decomposition:
- Shared package uart_pkg: DEPTH/AW defaults, TIMEOUT default, byte width constant (8).
- One natural sub-module: uart_sync_fifo (FWFT storage, pointers, level, full/empty).
- Synchroniser, edge detect, overrun, timeout and irq logic stay in uart_rx_ctrl.

Test Plan:
- Reset mid-push: assert reset one cycle after rx_ready rises -> no write; empty=1, level=0 after release; a later rx_ready edge writes normally.
- Single byte: rx_byte=0xA5, rx_ready 0->1 -> empty falls 2 edges later, rd_data=0xA5, level=1. Hold rx_ready high for 50 cycles -> level stays 1. Pulse rd_en -> empty=1.
- Fill/overrun: 9 bytes 0x01..0x09, no reads, DEPTH=8 -> full=1, overrun=1, irq=1. Reads return 0x01..0x08; 0x09 is lost. clr_overrun -> overrun=0.
- Simultaneous push/pop when full: byte 0x55 arrives on the same cycle as rd_en -> level stays 8, no overrun, 0x55 is the last byte read.
- Threshold: rx_thresh=3 -> irq=0 at level 2, irq=1 one cycle after level reaches 3. rx_thresh=0 with level 8 -> irq=0 unless overrun/timeout.
- Timeout (TIMEOUT=16): one byte, no reads -> timeout=1 and irq=1 after 15 idle cycles. Pop -> both clear. An empty FIFO never times out.
